// File: rtl/stage_4.sv
// rtl/stage_4.sv - commit/output stage: TX and RX commit FIFOs, drop counting, sticky overflow (optional drop counters: STAGE_4_DROP_CNT_EN)
module stage_4 #(
  parameter int data_size  = 32,
  parameter int tag_size   = 8,
  parameter int fifo_depth = 4,
  parameter int cnt_width  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    opcode_in,
  input  logic                          soft_error_in,
  input  logic [data_size+tag_size-1:0] tx_data_plus_tag_in,
  input  logic                          tag_match_in,
  input  logic [data_size-1:0]          rx_data_in,
  output logic                          net_tx_valid,
  output logic [data_size+tag_size-1:0] net_tx_data,
  input  logic                          net_tx_ready,
  output logic                          host_rx_valid,
  output logic [data_size-1:0]          host_rx_data,
  input  logic                          host_rx_ready,
  output logic                          tx_full,
  output logic                          rx_full,
  output logic                          overflow,
  output logic [cnt_width-1:0]          tx_drop_cnt,
  output logic [cnt_width-1:0]          rx_drop_cnt
);

  localparam int aw = $clog2(fifo_depth);
  localparam int tw = data_size + tag_size;

  localparam logic [1:0] op_tx    = 2'b01;
  localparam logic [1:0] op_rx    = 2'b10;
  localparam logic [1:0] op_flush = 2'b11;

  // Storage is deliberately not reset; empty FIFOs mask their heads to zero.
  logic [tw-1:0]        tx_mem [fifo_depth];
  logic [data_size-1:0] rx_mem [fifo_depth];

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [aw:0] tx_wr, tx_rd, rx_wr, rx_rd;

  logic tx_empty, rx_empty;
  logic tx_push_req, rx_push_req;
  logic tx_push, rx_push;
  logic tx_pop, rx_pop;
  logic flush;

  assign tx_empty = (tx_wr == tx_rd);
  assign rx_empty = (rx_wr == rx_rd);
  assign tx_full  = (tx_wr[aw] != tx_rd[aw]) && (tx_wr[aw-1:0] == tx_rd[aw-1:0]);
  assign rx_full  = (rx_wr[aw] != rx_rd[aw]) && (rx_wr[aw-1:0] == rx_rd[aw-1:0]);

  assign flush       = (opcode_in == op_flush);
  assign tx_push_req = (opcode_in == op_tx) && !soft_error_in;
  assign rx_push_req = (opcode_in == op_rx) && tag_match_in;

  // A full FIFO rejects the push even if its head leaves on the same edge.
  assign tx_push = tx_push_req && !tx_full;
  assign rx_push = rx_push_req && !rx_full;
  assign tx_pop  = !tx_empty && net_tx_ready;
  assign rx_pop  = !rx_empty && host_rx_ready;

  assign net_tx_valid  = !tx_empty;
  assign host_rx_valid = !rx_empty;
  assign net_tx_data   = tx_empty ? '0 : tx_mem[tx_rd[aw-1:0]];
  assign host_rx_data  = rx_empty ? '0 : rx_mem[rx_rd[aw-1:0]];

  // Write accepted words into FIFO storage.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[aw-1:0]] <= tx_data_plus_tag_in;
    if (rx_push) rx_mem[rx_wr[aw-1:0]] <= rx_data_in;
  end

  // Advance FIFO pointers; flush drops everything buffered, including a same-cycle pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
    end else if (flush) begin
      tx_rd <= tx_wr;
      rx_rd <= rx_wr;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
    end
  end

  // Sticky flag: set whenever a valid commit finds its FIFO full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if ((tx_push_req && tx_full) || (rx_push_req && rx_full)) begin
      overflow <= 1'b1;
    end
  end

`ifdef STAGE_4_DROP_CNT_EN
  logic [cnt_width-1:0] tx_drop_q, rx_drop_q;

  // Saturating counts of TX soft-error drops and RX tag-mismatch drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_drop_q <= '0;
      rx_drop_q <= '0;
    end else begin
      if ((opcode_in == op_tx) && soft_error_in && (tx_drop_q != '1))
        tx_drop_q <= tx_drop_q + 1'b1;
      if ((opcode_in == op_rx) && !tag_match_in && (rx_drop_q != '1))
        rx_drop_q <= rx_drop_q + 1'b1;
    end
  end

  assign tx_drop_cnt = tx_drop_q;
  assign rx_drop_cnt = rx_drop_q;
`else
  assign tx_drop_cnt = '0;
  assign rx_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_4.sv
// tb/tb_stage_4.sv - self-checking bench for stage_4 with a queue-based reference model
module tb_stage_4;

  localparam int DW    = 32;
  localparam int TGW   = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

`ifdef STAGE_4_DROP_CNT_EN
  localparam bit cnt_en = 1'b1;
`else
  localparam bit cnt_en = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        opcode_in = 2'b00;
  logic              soft_error_in = 1'b0;
  logic [DW+TGW-1:0] tx_data_plus_tag_in = '0;
  logic              tag_match_in = 1'b0;
  logic [DW-1:0]     rx_data_in = '0;
  logic              net_tx_valid;
  logic [DW+TGW-1:0] net_tx_data;
  logic              net_tx_ready = 1'b0;
  logic              host_rx_valid;
  logic [DW-1:0]     host_rx_data;
  logic              host_rx_ready = 1'b0;
  logic              tx_full, rx_full, overflow;
  logic [CW-1:0]     tx_drop_cnt, rx_drop_cnt;

  int errors = 0;
  int checks = 0;

  stage_4 #(.data_size(DW), .tag_size(TGW), .fifo_depth(DEPTH), .cnt_width(CW)) dut (
    .clk(clk), .reset(reset), .opcode_in(opcode_in), .soft_error_in(soft_error_in),
    .tx_data_plus_tag_in(tx_data_plus_tag_in), .tag_match_in(tag_match_in),
    .rx_data_in(rx_data_in), .net_tx_valid(net_tx_valid), .net_tx_data(net_tx_data),
    .net_tx_ready(net_tx_ready), .host_rx_valid(host_rx_valid), .host_rx_data(host_rx_data),
    .host_rx_ready(host_rx_ready), .tx_full(tx_full), .rx_full(rx_full), .overflow(overflow),
    .tx_drop_cnt(tx_drop_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: plain queues holding what each FIFO should contain.
  logic [DW+TGW-1:0] mtx[$];
  logic [DW-1:0]     mrx[$];
  bit                movf = 1'b0;
  int                mtxd = 0;
  int                mrxd = 0;
  int                tn, rn;
  bit                tpop, rpop;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtx.delete(); mrx.delete();
      movf = 1'b0; mtxd = 0; mrxd = 0;
    end else begin
      tn = mtx.size();
      rn = mrx.size();
      tpop = (tn > 0) && net_tx_ready;
      rpop = (rn > 0) && host_rx_ready;
      if (opcode_in == 2'b11) begin
        mtx.delete(); mrx.delete();
      end else begin
        if (tpop) void'(mtx.pop_front());
        if (rpop) void'(mrx.pop_front());
        if (opcode_in == 2'b01) begin
          if (soft_error_in) begin
            if (cnt_en && mtxd < 255) mtxd++;
          end else if (tn < DEPTH) mtx.push_back(tx_data_plus_tag_in);
          else movf = 1'b1;
        end
        if (opcode_in == 2'b10) begin
          if (!tag_match_in) begin
            if (cnt_en && mrxd < 255) mrxd++;
          end else if (rn < DEPTH) mrx.push_back(rx_data_in);
          else movf = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("m_tx_valid", 64'(net_tx_valid), 64'(mtx.size() > 0));
    chk("m_tx_data", 64'(net_tx_data), (mtx.size() > 0) ? 64'(mtx[0]) : 64'd0);
    chk("m_tx_full", 64'(tx_full), 64'(mtx.size() == DEPTH));
    chk("m_rx_valid", 64'(host_rx_valid), 64'(mrx.size() > 0));
    chk("m_rx_data", 64'(host_rx_data), (mrx.size() > 0) ? 64'(mrx[0]) : 64'd0);
    chk("m_rx_full", 64'(rx_full), 64'(mrx.size() == DEPTH));
    chk("m_overflow", 64'(overflow), 64'(movf));
    chk("m_tx_drop", 64'(tx_drop_cnt), 64'(mtxd));
    chk("m_rx_drop", 64'(rx_drop_cnt), 64'(mrxd));
  end

  // Apply one set of inputs across exactly one rising edge; returns at the next falling edge.
  task automatic step(input logic [1:0] op, input logic se, input logic [39:0] txd,
                      input logic tm, input logic [31:0] rxd, input logic txr, input logic rxr);
    opcode_in = op; soft_error_in = se; tx_data_plus_tag_in = txd;
    tag_match_in = tm; rx_data_in = rxd; net_tx_ready = txr; host_rx_ready = rxr;
    @(negedge clk);
  endtask

  logic [1:0] ops [8] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b01, 2'b11};

  initial begin
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: asynchronous reset while traffic is buffered
    step(2'b01, 0, 40'h11, 0, 0, 0, 0);
    step(2'b10, 0, 0, 1, 32'h22, 0, 0);
    chk("t1_pre_valid", 64'(net_tx_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t1_tx_valid", 64'(net_tx_valid), 64'd0);
    chk("t1_tx_data", 64'(net_tx_data), 64'd0);
    chk("t1_rx_valid", 64'(host_rx_valid), 64'd0);
    chk("t1_rx_data", 64'(host_rx_data), 64'd0);
    chk("t1_full", 64'({tx_full, rx_full, overflow}), 64'd0);
    chk("t1_cnts", 64'({tx_drop_cnt, rx_drop_cnt}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step(2'b00, 0, 0, 0, 0, 0, 0);
    chk("t1_post_empty", 64'({net_tx_valid, host_rx_valid}), 64'd0);

    // 2: TX commit then soft-error drop
    step(2'b01, 0, 40'hDEADBEEFA5, 0, 0, 0, 0);
    chk("t2_valid", 64'(net_tx_valid), 64'd1);
    chk("t2_data", 64'(net_tx_data), 64'hDEADBEEFA5);
    step(2'b01, 1, 40'h77, 0, 0, 0, 0);
    chk("t2_drop", 64'(tx_drop_cnt), cnt_en ? 64'd1 : 64'd0);
    chk("t2_data_kept", 64'(net_tx_data), 64'hDEADBEEFA5);
    step(2'b11, 0, 0, 0, 0, 0, 0);

    // 3: RX commit popped immediately, then tag-mismatch drop
    step(2'b10, 0, 0, 1, 32'h12345678, 0, 1);
    chk("t3_valid", 64'(host_rx_valid), 64'd1);
    chk("t3_data", 64'(host_rx_data), 64'h12345678);
    step(2'b00, 0, 0, 0, 0, 0, 1);
    chk("t3_popped", 64'(host_rx_valid), 64'd0);
    step(2'b10, 0, 0, 0, 32'h9999, 0, 1);
    chk("t3_drop", 64'(rx_drop_cnt), cnt_en ? 64'd1 : 64'd0);
    chk("t3_still_empty", 64'(host_rx_valid), 64'd0);

    // 4: fill, overflow, drain in order
    for (int i = 1; i <= 5; i++) begin
      step(2'b01, 0, 40'(i), 0, 0, 0, 0);
      if (i == 4) chk("t4_full", 64'(tx_full), 64'd1);
    end
    chk("t4_overflow", 64'(overflow), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t4_drain", 64'(net_tx_data), 64'(i));
      step(2'b00, 0, 0, 0, 0, 1, 0);
    end
    chk("t4_empty", 64'(net_tx_valid), 64'd0);
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);

    // 5: push while full with simultaneous pop
    for (int i = 10; i <= 13; i++) step(2'b01, 0, 40'(i), 0, 0, 0, 0);
    step(2'b01, 0, 40'd9, 0, 0, 1, 0);
    chk("t5_not_full", 64'(tx_full), 64'd0);
    chk("t5_head", 64'(net_tx_data), 64'd11);
    for (int i = 11; i <= 13; i++) begin
      chk("t5_drain", 64'(net_tx_data), 64'(i));
      step(2'b00, 0, 0, 0, 0, 1, 0);
    end
    chk("t5_nine_absent", 64'(net_tx_valid), 64'd0);

    // 6: flush with both FIFOs occupied and both ready
    for (int i = 1; i <= 3; i++) step(2'b01, 0, 40'(i + 32), 0, 0, 0, 0);
    for (int i = 1; i <= 2; i++) step(2'b10, 0, 0, 1, 32'(i + 64), 0, 0);
    step(2'b11, 0, 0, 0, 0, 1, 1);
    chk("t6_flush", 64'({net_tx_valid, host_rx_valid}), 64'd0);
    chk("t6_cnt_kept", 64'(tx_drop_cnt), cnt_en ? 64'd1 : 64'd0);
    for (int i = 0; i < 256; i++) step(2'b01, 1, 40'(i), 0, 0, 0, 0);
    chk("t6_saturate", 64'(tx_drop_cnt), cnt_en ? 64'd255 : 64'd0);

    // Mixed traffic checked only by the model
    for (int i = 0; i < 80; i++)
      step(ops[i % 8], (i % 5) == 2, 40'(i * 32'h01010101), (i % 4) != 3,
           32'(i * 32'h00370011), (i % 3) != 0, (i % 2) == 0);
    step(2'b00, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
